// File: rtl/sub_share_ctrl_pkg.sv
// sub_share_ctrl_pkg: shared constants, requester ids and clog2 for the subtractor-sharing controller
package sub_share_ctrl_pkg;
    localparam int NREQ = 2;
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sub_tag_pipe.sv
// sub_tag_pipe: DEPTH-stage shift register of {vld, id} tracking in-flight subtract ops
// Ports: clk, reset (async active-low), in_vld/in_id (stage 0 input),
//        out_vld/out_id (final stage), any_vld (OR of all stage valids)
module sub_tag_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_vld,
    input  logic in_id,
    output logic out_vld,
    output logic out_id,
    output logic any_vld
);
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] id;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            id  <= '0;
        end else begin
            vld[0] <= in_vld;
            id[0]  <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                id[i]  <= id[i-1];
            end
        end
    end
    assign out_vld = vld[DEPTH-1];
    assign out_id  = id[DEPTH-1];
    assign any_vld = |vld;
endmodule

// File: rtl/sub_share_ctrl.sv
// sub_share_ctrl: round-robin sharing of one pipelined W-bit subtract/compare unit between two requesters
// Ports: clk, reset (async active-low); reqN_valid/a/b/ready request handshakes;
//        sub_a/sub_b operands to the unit, sub_diff/cout/ovf results back SUB_LAT cycles later;
//        rsp_valid (one-hot owner), rsp_diff/zero/lt/ovf response data; busy while ops are in flight
module sub_share_ctrl
    import sub_share_ctrl_pkg::*;
#(
    parameter int W       = 8,
    parameter int SUB_LAT = 4,
    parameter int MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic [W-1:0] sub_a,
    output logic [W-1:0] sub_b,
    input  logic [W-1:0] sub_diff,
    input  logic         sub_cout,
    input  logic         sub_ovf,
    output logic [1:0]   rsp_valid,
    output logic [W-1:0] rsp_diff,
    output logic         rsp_zero,
    output logic         rsp_lt,
    output logic         rsp_ovf,
    output logic         busy
);
    localparam int CW = clog2(MAX_OUT + 1);
    logic [CW-1:0]   cnt [NREQ];
    logic [NREQ-1:0] valid, elig, grant;
    logic            ptr, iss_vld, iss_id, tag_vld, tag_id, tag_busy, xfer;
    assign valid = {req1_valid, req0_valid};
    // ptr names the requester preferred on a tie, i.e. the one not granted last;
    // grants are gated by reset so ready stays low while reset is held
    always_comb begin
        for (int i = 0; i < NREQ; i++) elig[i] = valid[i] && (cnt[i] < CW'(MAX_OUT));
        grant[1] = reset && elig[1] && (!elig[0] || ptr == REQ1);
        grant[0] = reset && elig[0] && !grant[1];
    end
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= REQ0;
            iss_vld <= 1'b0;
            iss_id  <= 1'b0;
            sub_a   <= '0;
            sub_b   <= '0;
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            iss_vld <= xfer;
            iss_id  <= grant[1];
            if (xfer) begin
                ptr   <= !grant[1];
                sub_a <= grant[1] ? req1_a : req0_a;
                sub_b <= grant[1] ? req1_b : req0_b;
            end
            for (int i = 0; i < NREQ; i++) cnt[i] <= cnt[i] + CW'(grant[i]) - CW'(rsp_valid[i]);
        end
    end
    // The issue register marks the cycle the unit sees the operands; the tag
    // pipe then follows the unit's SUB_LAT-cycle latency to the result
    sub_tag_pipe #(.DEPTH(SUB_LAT)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (iss_vld),
        .in_id   (iss_id),
        .out_vld (tag_vld),
        .out_id  (tag_id),
        .any_vld (tag_busy)
    );
    assign busy      = tag_busy || iss_vld;
    assign rsp_valid = tag_vld ? (tag_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_diff  = tag_vld ? sub_diff : '0;
    assign rsp_zero  = tag_vld && (sub_diff == '0);
    assign rsp_lt    = tag_vld && !sub_cout;
    assign rsp_ovf   = tag_vld && sub_ovf && !rsp_zero;
endmodule

// File: tb/tb_sub_share_ctrl.sv
// tb_sub_share_ctrl: directed self-checking bench for sub_share_ctrl with a 4-cycle subtractor model
module tb_sub_share_ctrl;
    logic       clk = 0;
    logic       reset = 0;
    logic       req0_valid = 0, req1_valid = 0;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       req0_ready, req1_ready;
    logic [7:0] sub_a, sub_b, sub_diff;
    logic       sub_cout, sub_ovf;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_diff;
    logic       rsp_zero, rsp_lt, rsp_ovf, busy;
    logic       ovf_force = 0;
    int         tests = 0, fails = 0;

    sub_share_ctrl #(.W(8), .SUB_LAT(4), .MAX_OUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff), .sub_cout(sub_cout), .sub_ovf(sub_ovf),
        .rsp_valid(rsp_valid), .rsp_diff(rsp_diff), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt),
        .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared unit model: result appears 4 cycles after the operands are presented
    logic [7:0] dd;
    logic [7:0] pd [4];
    logic       pc [4], po [4];
    assign dd = sub_a - sub_b;
    always_ff @(posedge clk) begin
        pd[0] <= dd;
        pc[0] <= sub_a >= sub_b;
        po[0] <= (sub_a[7] != sub_b[7]) && (dd[7] != sub_a[7]);
        for (int i = 1; i < 4; i++) begin
            pd[i] <= pd[i-1];
            pc[i] <= pc[i-1];
            po[i] <= po[i-1];
        end
    end
    assign sub_diff = pd[3];
    assign sub_cout = pc[3];
    assign sub_ovf  = po[3] | ovf_force;

    // One op from one requester; cycle numbers count from the handshake cycle (0)
    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b, output logic rdy,
                          output int cyc, output logic [1:0] v, output logic [7:0] d,
                          output logic z, output logic l, output logic o, output int n);
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else begin req0_valid = 1; req0_a = a; req0_b = b; end
        @(negedge clk);
        rdy = id ? req1_ready : req0_ready;
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        cyc = -1; n = 0; v = 0; d = 0; z = 0; l = 0; o = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                n++;
                if (cyc < 0) begin cyc = k; v = rsp_valid; d = rsp_diff; z = rsp_zero; l = rsp_lt; o = rsp_ovf; end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        req0_valid = 1;
        #2;
        tests++; if (req0_ready !== 0) begin fails++; $display("FAIL reset_ready got %b exp 0", req0_ready); end
        tests++; if (sub_a !== 0 || sub_b !== 0) begin fails++; $display("FAIL reset_operands got %h/%h exp 00/00", sub_a, sub_b); end
        tests++; if ({rsp_valid, rsp_diff, rsp_zero, rsp_lt, rsp_ovf, busy} !== 0) begin fails++; $display("FAIL reset_rsp got v=%b d=%h busy=%b exp all 0", rsp_valid, rsp_diff, busy); end
        req0_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_single();
        logic r, z, l, o; int cyc, n; logic [1:0] v; logic [7:0] d;
        run_op(0, 8'd200, 8'd55, r, cyc, v, d, z, l, o, n);
        tests++; if (r !== 1) begin fails++; $display("FAIL single_ready got %b exp 1", r); end
        tests++; if (cyc !== 5) begin fails++; $display("FAIL single_latency got %0d exp 5", cyc); end
        tests++; if (n !== 1) begin fails++; $display("FAIL single_count got %0d exp 1", n); end
        tests++; if (v !== 2'b01 || d !== 8'd145) begin fails++; $display("FAIL single_data got v=%b d=%0d exp v=01 d=145", v, d); end
        tests++; if ({z, l, o} !== 3'b000) begin fails++; $display("FAIL single_flags got zlo=%b%b%b exp 000", z, l, o); end
    endtask

    task automatic test_equal();
        logic r, z, l, o; int cyc, n; logic [1:0] v; logic [7:0] d;
        ovf_force = 1;
        run_op(1, 8'h3C, 8'h3C, r, cyc, v, d, z, l, o, n);
        ovf_force = 0;
        tests++; if (cyc !== 5 || v !== 2'b10) begin fails++; $display("FAIL equal_valid got cyc=%0d v=%b exp 5/10", cyc, v); end
        tests++; if (d !== 0 || {z, l, o} !== 3'b100) begin fails++; $display("FAIL equal_flags got d=%h zlo=%b%b%b exp 00/100", d, z, l, o); end
    endtask

    task automatic test_borrow();
        logic r, z, l, o; int cyc, n; logic [1:0] v; logic [7:0] d;
        run_op(0, 8'd5, 8'd9, r, cyc, v, d, z, l, o, n);
        tests++; if (v !== 2'b01 || d !== 8'hFC) begin fails++; $display("FAIL borrow_data got v=%b d=%h exp 01/fc", v, d); end
        tests++; if ({z, l, o} !== 3'b010) begin fails++; $display("FAIL borrow_flags got zlo=%b%b%b exp 010", z, l, o); end
    endtask

    task automatic test_contention();
        logic [8:0] expq [$];
        logic [8:0] e;
        logic       exp_id;
        int         nr;
        exp_id = 1;
        nr = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            req0_valid = c < 8; req0_a = 8'(20 + c); req0_b = 8'd3;
            req1_valid = c < 8; req1_a = 8'(200 + c); req1_b = 8'd100;
            @(negedge clk);
            if (c < 8) begin
                tests++; if (req0_ready == req1_ready) begin fails++; $display("FAIL contend_one_grant c=%0d got %b%b exp exactly one", c, req1_ready, req0_ready); end
                tests++; if (req1_ready !== exp_id) begin fails++; $display("FAIL contend_order c=%0d got req1_ready=%b exp %b", c, req1_ready, exp_id); end
                exp_id = !exp_id;
                if (req0_ready || req1_ready) expq.push_back({req1_ready, req1_ready ? 8'(100 + c) : 8'(17 + c)});
            end
            if (rsp_valid != 0) begin
                nr++;
                tests++;
                if (expq.size() == 0) begin fails++; $display("FAIL contend_rsp c=%0d got v=%b exp none", c, rsp_valid); end
                else begin
                    e = expq.pop_front();
                    if (rsp_valid !== (e[8] ? 2'b10 : 2'b01) || rsp_diff !== e[7:0]) begin
                        fails++; $display("FAIL contend_rsp c=%0d got v=%b d=%0d exp id=%b d=%0d", c, rsp_valid, rsp_diff, e[8], e[7:0]);
                    end
                end
            end
        end
        req0_valid = 0; req1_valid = 0;
        tests++; if (nr !== 8) begin fails++; $display("FAIL contend_count got %0d exp 8", nr); end
    endtask

    task automatic test_throttle();
        logic e0, e1;
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
            req0_valid = c < 7; req0_a = 8'(c); req0_b = 0;
            req1_valid = c == 4 || c == 5; req1_a = 8'(c); req1_b = 0;
            @(negedge clk);
            if (c < 7) begin
                e1 = c == 4 || c == 5;
                e0 = !e1;
                tests++; if (req0_ready !== e0 || req1_ready !== e1) begin fails++; $display("FAIL throttle c=%0d got r0=%b r1=%b exp r0=%b r1=%b", c, req0_ready, req1_ready, e0, e1); end
            end
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        tests++; if (busy !== 0) begin fails++; $display("FAIL throttle_drain busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic r, z, l, o; int cyc, n, bad; logic [1:0] v; logic [7:0] d;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req0_valid = 1; req0_a = 8'(90 + c); req0_b = 8'd1;
        end
        @(posedge clk); #1;
        tests++; if (busy !== 1) begin fails++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
        reset = 0;
        #1;
        tests++; if (req0_ready !== 0 || busy !== 0) begin fails++; $display("FAIL midrst_ctrl got ready=%b busy=%b exp 0/0", req0_ready, busy); end
        tests++; if (sub_a !== 0 || sub_b !== 0 || rsp_valid !== 0 || rsp_diff !== 0) begin fails++; $display("FAIL midrst_data got a=%h b=%h v=%b d=%h exp 0", sub_a, sub_b, rsp_valid, rsp_diff); end
        repeat (2) @(posedge clk);
        #1 req0_valid = 0;
        reset = 1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL midrst_ghost got %0d responses exp 0", bad); end
        run_op(1, 8'd50, 8'd20, r, cyc, v, d, z, l, o, n);
        tests++; if (cyc !== 5 || v !== 2'b10 || d !== 8'd30 || n !== 1) begin fails++; $display("FAIL midrst_new got cyc=%0d v=%b d=%0d n=%0d exp 5/10/30/1", cyc, v, d, n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_equal();
        test_borrow();
        test_contention();
        test_throttle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
